// File: rtl/score_display_pkg.sv
// score_display_pkg: segment codes, conversion FSM states and digit decoder
// shared by the score display driver and its BCD converter.
package score_display_pkg;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p *= 10;
        return p;
    endfunction
endpackage

// File: rtl/score_display_mux_bin2bcd.sv
// bin2bcd_seq: iterative double-dabble, one bit per cycle, with a one-cycle
// DONE state during which bcd holds the finished result.
module bin2bcd_seq
    import score_display_pkg::*;
#(
    parameter int BIN_WIDTH = 7,
    parameter int DIGITS    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    // One spare nibble so values up to 10^(DIGITS+1)-1 convert without wrap.
    localparam int NIB = DIGITS + 1;
    localparam int CW  = $clog2(BIN_WIDTH + 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [4*NIB-1:0]    acc;
    logic [4*NIB-1:0]    adj;
    logic [BIN_WIDTH-1:0] sr;

    always_comb begin
        adj = acc;
        for (int i = 0; i < NIB; i++)
            adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
            sr    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    sr    <= bin;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {acc, sr} <= {adj, sr} << 1;
                    cnt       <= cnt + 1'b1;
                    if (cnt == CW'(BIN_WIDTH - 1)) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = state != ST_IDLE;
    assign done = state == ST_DONE;
    assign bcd  = acc[4*DIGITS-1:0];
endmodule

// File: rtl/score_display_mux.sv
// score_display_mux: latches a score, converts it to BCD and scans it over
// DIGITS multiplexed 7-segment digits with blanking and overflow dashes.
module score_display_mux
    import score_display_pkg::*;
#(
    parameter int DIGITS        = 2,
    parameter int BIN_WIDTH     = 7,
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_LEADING = 1,
    parameter int INVERT_OUTPUT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIN_WIDTH-1:0] N_in,
    input  logic                 update,
    output logic                 busy,
    output logic                 overflow,
    output logic [6:0]           N_out,
    output logic [DIGITS-1:0]    digit_en
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [31:0]       LIMIT  = 32'(pow10(DIGITS));
    localparam logic [6:0]        INV    = INVERT_OUTPUT != 0 ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] INV_EN = INVERT_OUTPUT != 0 ? '1 : '0;

    logic                start;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [4*DIGITS-1:0] disp;
    logic                disp_ovf;
    logic [SW-1:0]       scan;
    logic [IW-1:0]       idx;
    logic [3:0]          nib;
    logic                blank;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   en;

    assign start = update & ~busy;

    bin2bcd_seq #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (N_in),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        nib   = 4'(disp >> (4*idx));
        blank = BLANK_LEADING != 0 && idx != '0 && (disp >> (4*idx)) == '0;
        seg   = disp_ovf ? SEG_DASH : blank ? SEG_BLANK : seg_decode(nib);
        en    = DIGITS'(1) << idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            disp     <= '0;
            disp_ovf <= 1'b0;
            scan     <= '0;
            idx      <= '0;
            N_out    <= INV;
            digit_en <= INV_EN;
        end else begin
            if (start) overflow <= 32'(N_in) >= LIMIT;
            if (done) begin
                disp     <= bcd;
                disp_ovf <= overflow;
            end
            scan <= scan == SW'(SCAN_DIV - 1) ? '0 : scan + 1'b1;
            if (scan == SW'(SCAN_DIV - 1)) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
            N_out    <= seg ^ INV;
            digit_en <= en ^ INV_EN;
        end
    end
endmodule

// File: tb/tb_score_display_mux.sv
// tb_score_display_mux: two configurations driven in parallel, checked every
// cycle against an arithmetic model, plus directed literal expectations.
module tb_score_display_mux;
    localparam int BW = 7;

    logic          clk = 0;
    logic          rst_n = 1;
    logic          update = 0;
    logic [BW-1:0] n_in = '0;
    logic          busy_a, ovf_a, busy_b, ovf_b;
    logic [6:0]    seg_a, seg_b;
    logic [1:0]    en_a, en_b;
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    score_display_mux #(.DIGITS(2), .BIN_WIDTH(BW), .SCAN_DIV(4), .BLANK_LEADING(1), .INVERT_OUTPUT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .N_in(n_in), .update(update),
        .busy(busy_a), .overflow(ovf_a), .N_out(seg_a), .digit_en(en_a)
    );

    score_display_mux #(.DIGITS(2), .BIN_WIDTH(BW), .SCAN_DIV(3), .BLANK_LEADING(0), .INVERT_OUTPUT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .N_in(n_in), .update(update),
        .busy(busy_b), .overflow(ovf_b), .N_out(seg_b), .digit_en(en_b)
    );

    logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] code(input int v, input bit ovf, input int d, input bit bl);
        int p = (d == 0) ? 1 : 10;
        if (ovf) return 7'h40;
        if (bl && d > 0 && v / p == 0) return 7'h00;
        return segtab[(v / p) % 10];
    endfunction

    // Model: value shown, pending conversion countdown, edges since reset.
    int         m_disp = 0, m_pend = 0, m_left = 0, m_edges = 0;
    bit         m_ovf = 0, m_dovf = 0;
    logic [6:0] exp_a_seg = 7'h00, exp_b_seg = 7'h7F;
    logic [1:0] exp_a_en = 2'b00, exp_b_en = 2'b11;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_disp <= 0; m_pend <= 0; m_left <= 0; m_edges <= 0; m_ovf <= 0; m_dovf <= 0;
            exp_a_seg <= 7'h00; exp_a_en <= 2'b00; exp_b_seg <= 7'h7F; exp_b_en <= 2'b11;
        end else begin
            m_edges   <= m_edges + 1;
            exp_a_seg <= code(m_disp, m_dovf, (m_edges / 4) % 2, 1);
            exp_a_en  <= 2'(1 << ((m_edges / 4) % 2));
            exp_b_seg <= ~code(m_disp, m_dovf, (m_edges / 3) % 2, 0);
            exp_b_en  <= ~2'(1 << ((m_edges / 3) % 2));
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_disp <= m_pend % 100;
                    m_dovf <= m_ovf;
                end
            end else if (update) begin
                m_pend <= int'(n_in);
                m_ovf  <= n_in >= 7'd100;
                m_left <= BW + 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        chk("model seg_a", seg_a, exp_a_seg);
        chk("model en_a", en_a, exp_a_en);
        chk("model seg_b", seg_b, exp_b_seg);
        chk("model en_b", en_b, exp_b_en);
        chk("model busy_a", busy_a, m_left > 0);
        chk("model busy_b", busy_b, m_left > 0);
        chk("model ovf_a", ovf_a, m_ovf);
        chk("model ovf_b", ovf_b, m_ovf);
    end

    task automatic pulse(input int v);
        @(negedge clk);
        n_in = 7'(v);
        update = 1;
        @(negedge clk);
        update = 0;
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_a && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (busy_a) chk("idle timeout", 1, 0);
    endtask

    task automatic wait_a(input logic [1:0] d);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (en_a !== d && n < 40);
        if (en_a !== d) chk("wait_a timeout", en_a, d);
    endtask

    task automatic wait_b(input logic [1:0] d);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (en_b !== d && n < 40);
        if (en_b !== d) chk("wait_b timeout", en_b, d);
    endtask

    initial begin
        int n;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset seg_a", seg_a, 7'h00);
        chk("reset en_a", en_a, 2'b00);
        chk("reset busy_a", busy_a, 0);
        chk("reset seg_b", seg_b, 7'h7F);
        chk("reset en_b", en_b, 2'b11);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #1;
        chk("first en_a", en_a, 2'b01);
        chk("first seg_a", seg_a, 7'h3F);
        wait_a(2'b10);
        chk("zero digit1 blank", seg_a, 7'h00);

        pulse(42);
        n = 0;
        while (busy_a && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("busy length", n, 8);
        wait_a(2'b10);
        chk("42 digit1", seg_a, 7'h66);
        wait_a(2'b01);
        chk("42 digit0", seg_a, 7'h5B);
        wait_b(2'b01);
        chk("42 inv digit1", seg_b, 7'h19);

        pulse(7);
        wait_idle();
        wait_a(2'b10);
        chk("7 digit1 blank", seg_a, 7'h00);
        wait_a(2'b01);
        chk("7 digit0", seg_a, 7'h07);
        wait_b(2'b01);
        chk("7 noblank digit1", seg_b, 7'h40);

        pulse(100);
        wait_idle();
        chk("100 overflow", ovf_a, 1);
        wait_a(2'b10);
        chk("100 dash1", seg_a, 7'h40);
        wait_a(2'b01);
        chk("100 dash0", seg_a, 7'h40);
        pulse(99);
        wait_idle();
        chk("99 overflow", ovf_a, 0);
        wait_a(2'b10);
        chk("99 digit1", seg_a, 7'h6F);
        wait_a(2'b01);
        chk("99 digit0", seg_a, 7'h6F);

        pulse(42);
        repeat (2) @(negedge clk);
        pulse(13);
        n = 0;
        while (m_left != 1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_in = 7'd13;
        update = 1;
        @(negedge clk);
        #1;
        chk("busy after done", busy_a, 0);
        n_in = 7'd55;
        @(negedge clk);
        update = 0;
        #1;
        chk("accept after done", busy_a, 1);
        chk("still 42", seg_a, en_a == 2'b01 ? 7'h5B : 7'h66);
        wait_idle();
        wait_a(2'b10);
        chk("55 digit1", seg_a, 7'h6D);

        pulse(42);
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        chk("abort busy_b", busy_b, 0);
        chk("abort seg_b", seg_b, 7'h7F);
        chk("abort en_b", en_b, 2'b11);
        chk("abort ovf_b", ovf_b, 0);
        @(negedge clk);
        rst_n = 1;
        wait_b(2'b10);
        chk("abort shows 0", seg_b, 7'h40);

        repeat (3000) begin
            @(negedge clk);
            n_in = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(95, 105)) : 7'($urandom_range(0, 127));
            update = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
        end
        @(negedge clk);
        rst_n = 1;
        update = 0;
        repeat (20) @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/score_display_mux.md
Name: score_display_mux

Overview:
Multi-digit, time-multiplexed 7-segment driver for the Pong score displays. It is the parametrised successor of the single-digit Display7Segment. It latches a binary score on an update strobe and converts it to BCD sequentially using iterative double-dabble. It then scans DIGITS common-anode/cathode digits over one shared segment bus, with leading-zero blanking and an overflow indication.

Parameters:
DIGITS, 2, number of decimal digits driven (1..4)
BIN_WIDTH, 7, width of binary input (must satisfy 2^BIN_WIDTH <= 10^(DIGITS+1))
SCAN_DIV, 50000, clock cycles each digit stays enabled (>=2)
BLANK_LEADING, 1, 1 = blank leading zero digits; digit 0 is never blanked
INVERT_OUTPUT, 0, 1 = N_out and digit_en are active-low (bitwise complement of all values below)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
N_in  in  BIN_WIDTH  binary value to display
update  in  1  single-cycle load strobe
busy  out  1  conversion in progress
overflow  out  1  latched value >= 10^DIGITS
N_out  out  7  segments {g,f,e,d,c,b,a} for the currently enabled digit
digit_en  out  DIGITS  one-hot digit enable; bit 0 = least significant digit

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, overflow=0, N_out=7'h00, digit_en=0 (both all-ones if INVERT_OUTPUT).
  - Displayed BCD=0, scan counter=0, digit index=0.
  - Asserting reset mid-conversion aborts the conversion; no partial result is kept.
- Load:
  - update=1 at a clock edge with busy=0 captures N_in into the shift register and registers overflow = (N_in >= 10^DIGITS).
  - busy=1 from the next cycle.
  - update while busy=1 is ignored: no restart and no requeue.
- Conversion: FSM IDLE -> SHIFT -> DONE -> IDLE.
  - SHIFT runs exactly BIN_WIDTH cycles. Each cycle it adds 3 to every BCD nibble >= 5, then shifts left by 1.
  - DONE lasts 1 cycle: the internal BCD (DIGITS nibbles, higher bits discarded) is copied to the display register and busy drops.
  - Total: busy high for BIN_WIDTH+1 cycles. The display register updates BIN_WIDTH+1 edges after the capturing edge.
  - The previous value remains displayed throughout conversion, so there is no flicker.
- Scan:
  - Free-running counter 0..SCAN_DIV-1. At the terminal count, the digit index advances 0,1,..,DIGITS-1 and wraps to 0.
  - Scanning is unaffected by update/busy.
  - N_out and digit_en are registered: they reflect the digit index and display register with 1 cycle latency.
  - Both change on the same edge, so there are no ghosting glitches.
  - First valid output is 1 cycle after reset release: digit_en=1, N_out=SEG_0.
- Segment codes:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, blank=00, dash=40.
  - BCD nibbles >9 cannot occur; decode them as blank.
- Blanking: with BLANK_LEADING=1, digit i>0 shows blank when it and all higher digits are zero.
- Overflow: while overflow=1, every digit shows dash, regardless of the BCD content and blanking.
  - overflow changes only on a load, and takes effect on the display together with the DONE copy, not at capture.
- Simultaneous events:
  - update arriving on the DONE cycle is ignored (busy still 1).
  - update arriving on the cycle after DONE is accepted.

Decomposition:
- Package score_display_pkg holds:
  - the segment constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH;
  - the FSM state enum;
  - a pure function seg_decode(nibble) -> 7 bits.
- Sub-module bin2bcd_seq (params BIN_WIDTH, DIGITS; ports clk, rst_n, start, bin, busy, done, bcd) owns the double-dabble FSM.
- The top level holds the load logic, overflow, display register, scan counter and output registers.

Test Plan:
1. Defaults with SCAN_DIV=4: hold reset, then release.
   -> During reset: N_out=00, digit_en=0, busy=0.
   -> After release: digit_en alternates 01/10 every 4 cycles, N_out=3F with digit 0 and 00 with digit 1.
2. N_in=42, update 1 cycle.
   -> busy=1 for exactly 8 cycles.
   -> Afterwards digit_en=10 shows 66 and digit_en=01 shows 5B.
3. N_in=7 then update.
   -> Digit 1 shows 00 (leading zero blanked), digit 0 shows 07.
   -> With BLANK_LEADING=0, digit 1 shows 3F instead.
4. N_in=100 then update.
   -> overflow=1 after DONE, both digits show 40.
   -> A following load of 99 clears overflow and shows 6F/6F.
5. Load 42; 3 cycles later pulse update with N_in=13; pulse update again on the DONE cycle.
   -> Both extra pulses ignored, display 42.
   -> A pulse 1 cycle after busy falls is accepted.
6. INVERT_OUTPUT=1: load 42, then assert rst_n=0 mid-conversion.
   -> Outputs complemented (digit_en=2'b01 for digit 1, N_out=19 for 4).
   -> On reset: busy=0 immediately, N_out=7F, digit_en=11, display value 0.
